// File: rtl/ysyx_22041207_pipe_stage.sv
// Two-entry skid buffer pipeline stage (IF/ID payload by default) with valid/ready on both sides.
// Optional stall counter enabled by defining YSYX_22041207_PIPE_STALL_CNT_EN.
module ysyx_22041207_pipe_stage #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and in_ready comes only from state.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_nxt;
    logic [DATA_W-1:0] tail;
    logic [DATA_W-1:0] tail_nxt;
    logic              push;
    logic              pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign occupancy = state;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        if (flush) begin
            state_nxt = EMPTY;
            head_nxt  = '0;
            tail_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        head_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_nxt = in_data;
                    end else if (push) begin
                        state_nxt = FULL;
                        tail_nxt  = in_data;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                        head_nxt  = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the buffer.
                    if (pop) begin
                        state_nxt = ONE;
                        head_nxt  = tail;
                        tail_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    head_nxt  = '0;
                    tail_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

`ifdef YSYX_22041207_PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating; flush deliberately leaves the count intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
